shift_arbiter: RTL and testbench
================================

// Module: shift_arbiter
// PURPOSE
//  Shares one 8-bit logical shifter between NREQ requesters with valid/ready handshakes.
//  Round-robin arbitration selects one request per cycle; the shifted result is registered.
//  The result is returned on a single response channel tagged with the requester index.
//  Sits between the command sources and the shifter datapath.
// PARAMETERS
//  W     8  data width (the shifter datapath is 8 bits; W must be 8)
//  SW    3  shift-amount width, log2(W)
//  NREQ  2  number of requesters, 2..4
//  IDW   1  response id width, clog2(NREQ) with a minimum of 1
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous assert, active-low reset
//  req_valid  in   NREQ       per-requester command valid
//  req_ready  out  NREQ       per-requester accept; at most one bit is high
//  req_x      in   NREQ*W     packed operands; requester i uses [i*W +: W]
//  req_shift  in   NREQ*SW    packed shift amounts
//  req_lr     in   NREQ       direction per requester: 1 = right, 0 = left
//  rsp_valid  out  1          result valid
//  rsp_ready  in   1          result accept
//  rsp_y      out  W          shifted result
//  rsp_id     out  IDW        index of the requester that issued the command
// BEHAVIOUR
//  Shift function
//   - lr=1: y = x >> shift. lr=0: y = x << shift.
//   - Logical shift, zero fill. shift=0 returns x unchanged.
//  Output slot
//   - A single register holds rsp_y, rsp_id and rsp_valid.
//   - FSM EMPTY: rsp_valid=0. FULL: rsp_valid=1.
//  Accept condition
//   - can_accept = EMPTY | (FULL & rsp_ready).
//   - When both a response drains and a command is accepted in the same cycle, the slot is reloaded and stays FULL.
//  FSM transitions
//   - EMPTY -> FULL on any accept.
//   - FULL -> EMPTY on rsp_ready with no accept.
//   - FULL stays FULL while rsp_ready=0. rsp_y and rsp_id are held stable.
//  Grant
//   - Combinational.
//   - Search starts at pointer ptr and proceeds upward, wrapping modulo NREQ.
//   - The first i with req_valid[i] is granted.
//   - req_ready[i] = can_accept & grant[i]. req_ready may depend on req_valid.
//  Pointer update
//   - On an accepted grant to i: ptr <= (i+1) mod NREQ.
//   - ptr is unchanged when no accept occurs, including when blocked by back-pressure.
//  Latency and throughput
//   - Latency: accept in cycle N gives rsp_valid=1 in cycle N+1.
//   - Throughput is 1 result per cycle while rsp_ready=1.
//  Fairness
//   - With all NREQ requesters continuously valid, grants rotate 0,1,..,NREQ-1,0,...
//  Handshake rules for requesters
//   - A requester must hold valid and its payload stable until ready.
//   - The arbiter never drops or duplicates a command.
//  Reset (async, rst_n=0)
//   - rsp_valid=0, rsp_y=0, rsp_id=0, ptr=0, FSM=EMPTY.
//   - req_ready=0 while rst_n=0.
//   - A command in flight at reset is discarded; a result pending at reset is lost.
//  Invalid shift amounts: not possible; shift values >= W are not representable in SW bits.
// STRUCTURE
//  Shared package shift_pkg
//   - Constants SHIFT_W=8 and SHIFT_SW=3.
//   - Localparams LR_RIGHT=1'b1 and LR_LEFT=1'b0.
//   - FSM state encoding: EMPTY=1'b0, FULL=1'b1.
//  Sub-module shift_core
//   - Combinational: x, shift, lr -> y, per the shift function above.
//   - Instantiated once, fed by the granted requester's mux output.
//  In this module
//   - Round-robin arbiter, operand mux, output slot FSM and registers, ptr register.
// TESTING
//  1 Reset: hold rst_n=0 with req_valid=2'b11 -> req_ready=0, rsp_valid=0; after release, first grant is id 0.
//  2 Single requester: req0 x=8'hB5, shift=3, lr=1; rsp_ready=1 -> next cycle rsp_y=8'h16, rsp_id=0.
//    Same with lr=0 -> rsp_y=8'hA8.
//  3 Contention: both valid every cycle with rsp_ready=1 -> ids alternate 0,1,0,1; one result per cycle; no gaps.
//  4 Back-pressure: result pending and rsp_ready=0 for 3 cycles -> rsp_y/rsp_id stable, req_ready=0, ptr frozen;
//    raising rsp_ready drains the slot and accepts the next command in the same cycle.
//  5 Boundaries: shift=0 with x=8'h81 -> 8'h81; shift=7 with lr=1 -> 8'h01; shift=7 with lr=0 -> 8'h80.
//  6 Mid-operation reset: assert rst_n with rsp_valid=1 -> rsp_valid=0 immediately; ptr=0.
//    Scoreboard check: no result from before reset appears after rst_n is released.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared constants and slot-state encoding for the shift arbiter and its shifter core.
package shift_pkg;

    localparam int SHIFT_W  = 8;
    localparam int SHIFT_SW = 3;

    localparam logic LR_RIGHT = 1'b1;
    localparam logic LR_LEFT  = 1'b0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/shift_core.sv
// Combinational logical shifter: zero-filled left or right shift of x by shift.
module shift_core
    import shift_pkg::*;
#(
    parameter int W  = SHIFT_W,
    parameter int SW = SHIFT_SW
) (
    input  logic [W-1:0]  x,
    input  logic [SW-1:0] shift,
    input  logic          lr,
    output logic [W-1:0]  y
);

    always_comb begin
        y = x;
        case (lr)
            LR_RIGHT: y = x >> shift;
            LR_LEFT:  y = x << shift;
            default:  y = x;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between NREQ requesters; one-deep registered
// response slot tagged with the requester index.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int W    = SHIFT_W,
    parameter int SW   = SHIFT_SW,
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*SW-1:0] req_shift,
    input  logic [NREQ-1:0]   req_lr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_y,
    output logic [IDW-1:0]    rsp_id
);

    slot_state_e    state;
    logic [IDW-1:0] ptr;

    logic [W-1:0]   x_arr  [NREQ];
    logic [SW-1:0]  sh_arr [NREQ];

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] ptr_nxt;
    logic           can_accept;
    logic           accept;

    logic [W-1:0]   x_sel;
    logic [SW-1:0]  sh_sel;
    logic           lr_sel;
    logic [W-1:0]   y_sh;

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign x_arr[i]  = req_x[i*W +: W];
        assign sh_arr[i] = req_shift[i*SW +: SW];
    end

    // Scan upward from ptr, wrapping; the first valid requester wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(ptr) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // rst_n gates accept so no requester sees ready while the slot is held in reset.
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign accept     = rst_n && can_accept && gnt_found;
    assign ptr_nxt    = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (gnt_idx == IDW'(i));
        end
    end

    assign x_sel  = x_arr[gnt_idx];
    assign sh_sel = sh_arr[gnt_idx];
    assign lr_sel = req_lr[gnt_idx];

    shift_core #(
        .W  (W),
        .SW (SW)
    ) u_core (
        .x     (x_sel),
        .shift (sh_sel),
        .lr    (lr_sel),
        .y     (y_sh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            rsp_y  <= '0;
            rsp_id <= '0;
            ptr    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) state <= FULL;
                end
                FULL: begin
                    if (!accept && rsp_ready) state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
            // A drain and a reload in the same cycle just overwrite the slot.
            if (accept) begin
                rsp_y  <= y_sh;
                rsp_id <= gnt_idx;
                ptr    <= ptr_nxt;
            end
        end
    end

    assign rsp_valid = (state == FULL);

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_slot_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_y) && $stable(rsp_id)));

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench: directed vectors and corner sequences, then random traffic vs a queue model.
module tb_shift_arbiter;

    localparam int N = 2;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [N*8-1:0] req_x;
    logic [N*3-1:0] req_shift;
    logic [N-1:0] req_lr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_y;
    logic [0:0]   rsp_id;

    int checks = 0;
    int errors = 0;

    shift_arbiter #(.W(8), .SW(3), .NREQ(N), .IDW(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_shift (req_shift),
        .req_lr    (req_lr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [2:0] sh;
        logic       lr;
        logic [7:0] y;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        int         id;
    } rsp_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference shifter built from plain integer arithmetic.
    function automatic logic [7:0] ref_shift(input logic [7:0] x, input int sh, input logic lr);
        int v;
        v = int'(x);
        if (lr) v = v / (2 ** sh);
        else    v = (v * (2 ** sh)) % 256;
        return v[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [2:0] sh, input logic lr);
        req_x[i*8 +: 8]     = x;
        req_shift[i*3 +: 3] = sh;
        req_lr[i]           = lr;
        req_valid[i]        = 1'b1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Random-phase model state
    logic [7:0] mx  [N];
    logic [2:0] msh [N];
    logic       mlr [N];
    bit         pend [N];
    bit         mfull;
    int         mptr;
    rsp_t       q[$];

    initial begin
        vecs[0] = '{x: 8'hB5, sh: 3'd3, lr: 1'b1, y: 8'h16};
        vecs[1] = '{x: 8'hB5, sh: 3'd3, lr: 1'b0, y: 8'hA8};
        vecs[2] = '{x: 8'h81, sh: 3'd0, lr: 1'b1, y: 8'h81};
        vecs[3] = '{x: 8'h81, sh: 3'd0, lr: 1'b0, y: 8'h81};
        vecs[4] = '{x: 8'hFF, sh: 3'd7, lr: 1'b1, y: 8'h01};
        vecs[5] = '{x: 8'hFF, sh: 3'd7, lr: 1'b0, y: 8'h80};
        vecs[6] = '{x: 8'h3C, sh: 3'd4, lr: 1'b1, y: 8'h03};
        vecs[7] = '{x: 8'h3C, sh: 3'd4, lr: 1'b0, y: 8'hC0};

        // Reset with both requesters valid
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_x = '0; req_shift = '0; req_lr = '0;
        set_req(0, 8'hB5, 3'd3, 1'b1);
        set_req(1, 8'h0F, 3'd1, 1'b0);
        #3;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_y", rsp_y, 8'h00);
        chk("rst_id", rsp_id, 1'b0);
        tick();
        chk("rst_ready_edge", req_ready, 2'b00);
        chk("rst_valid_edge", rsp_valid, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("first_grant", req_ready, 2'b01);
        tick();
        chk("first_rsp_valid", rsp_valid, 1'b1);
        chk("first_rsp_id", rsp_id, 1'b0);
        chk("first_rsp_y", rsp_y, 8'h16);

        // Directed vectors, alternating requester, back-to-back through a full slot
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            req_valid = '0;
            set_req(k % 2, vecs[k].x, vecs[k].sh, vecs[k].lr);
            #1;
            chk("vec_ready", req_ready, 32'(1) << (k % 2));
            tick();
            req_valid = '0;
            chk("vec_valid", rsp_valid, 1'b1);
            chk("vec_y", rsp_y, vecs[k].y);
            chk("vec_id", rsp_id, k % 2);
        end
        tick();
        chk("vec_drained", rsp_valid, 1'b0);

        // Contention: both valid, grants alternate with no gaps
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 8'hB5, 3'd3, 1'b0);
        set_req(1, 8'hB5, 3'd3, 1'b1);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("cont_ready", req_ready, 32'(1) << (c % 2));
            tick();
            chk("cont_valid", rsp_valid, 1'b1);
            chk("cont_id", rsp_id, c % 2);
            chk("cont_y", rsp_y, (c % 2 == 0) ? 8'hA8 : 8'h16);
        end

        // Back-pressure: slot held, ready low, pointer frozen
        do_reset();
        req_valid = '0;
        set_req(0, 8'hC3, 3'd2, 1'b1);
        tick();
        req_valid = '0;
        set_req(0, 8'h0F, 3'd1, 1'b1);
        set_req(1, 8'h5A, 3'd1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", req_ready, 2'b00);
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_y", rsp_y, 8'h30);
            chk("bp_id", rsp_id, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 2'b10);
        tick();
        req_valid[1] = 1'b0;
        chk("bp_next_id", rsp_id, 1'b1);
        chk("bp_next_y", rsp_y, 8'hB4);
        tick();
        req_valid = '0;
        chk("bp_after_id", rsp_id, 1'b0);
        chk("bp_after_y", rsp_y, 8'h07);
        tick();
        chk("bp_empty", rsp_valid, 1'b0);

        // Mid-operation reset drops the pending result
        do_reset();
        set_req(0, 8'h81, 3'd0, 1'b1);
        tick();
        req_valid = '0;
        chk("mid_full", rsp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_y", rsp_y, 8'h00);
        set_req(0, 8'h11, 3'd1, 1'b1);
        set_req(1, 8'h22, 3'd1, 1'b1);
        #1;
        chk("mid_rst_ready", req_ready, 2'b00);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_ptr_zero", req_ready, 2'b01);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("mid_no_ghost", rsp_valid, 1'b0);
        end

        // Random traffic against a queue/pointer model
        do_reset();
        mfull = 1'b0;
        mptr  = 0;
        q.delete();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int   g;
            logic [N-1:0] exp_rdy;
            bit   drain;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 100) < 60) begin
                    mx[i]  = 8'($urandom);
                    msh[i] = 3'($urandom);
                    mlr[i] = 1'($urandom);
                    pend[i] = 1'b1;
                end
                req_x[i*8 +: 8]     = mx[i];
                req_shift[i*3 +: 3] = msh[i];
                req_lr[i]           = mlr[i];
                req_valid[i]        = pend[i];
            end
            rsp_ready = (($urandom % 4) != 0);
            #1;
            g = -1;
            if (!mfull || rsp_ready) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
                end
            end
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("rnd_ready", req_ready, exp_rdy);
            chk("rnd_valid", rsp_valid, mfull);
            drain = mfull && rsp_ready;
            if (mfull && q.size() > 0) begin
                chk("rnd_y", rsp_y, q[0].y);
                chk("rnd_id", rsp_id, q[0].id);
            end
            if (drain && q.size() > 0) void'(q.pop_front());
            if (g >= 0) begin
                q.push_back('{y: ref_shift(mx[g], int'(msh[g]), mlr[g]), id: g});
                pend[g] = 1'b0;
                mptr    = (g + 1) % N;
                mfull   = 1'b1;
            end else if (drain) begin
                mfull = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
